// File: rtl/vliw_rf_pkg.sv
// vliw_rf_pkg: shared defaults and flattened-port slice helpers for the multi-ported register file.
package vliw_rf_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int NUM_REGS_DEF = 32;
  localparam int ZERO_ADDR = 0;
  function automatic int aw_of(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one registered read port with highest-index-wins write bypass and zero/out-of-range masking.
module rf_read_port import vliw_rf_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_WR = 2,
  parameter int AW = aw_of(NUM_REGS),
  parameter bit ZERO_EN = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_en,
  input  logic [AW-1:0]            rd_addr,
  input  logic [DATA_W-1:0]        arr_word,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid
);
  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic rd_valid_q;
  // Later ports overwrite earlier ones so the highest-index writer wins; masking then covers r0/out-of-range.
  always_comb begin
    rd_data_d = arr_word;
    for (int k = 0; k < NUM_WR; k++)
      if (wr_en[k] && wr_addr[lo(k, AW) +: AW] == rd_addr) rd_data_d = wr_data[lo(k, DATA_W) +: DATA_W];
    if (32'(rd_addr) >= NUM_REGS || (ZERO_EN && rd_addr == AW'(ZERO_ADDR))) rd_data_d = '0;
  end
  always_ff @(posedge clk) begin
    rd_data_q <= reset ? '0 : (rd_en ? rd_data_d : rd_data_q);
    rd_valid_q <= !reset && rd_en;
  end
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: rtl/vliw_regfile_mp.sv
// vliw_regfile_mp: NUM_RD-read / NUM_WR-write register file with write-first bypass and collision flag.
// Define VLIW_RF_ZERO_REG_EN to hardwire entry 0 to zero.
module vliw_regfile_mp import vliw_rf_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2,
  localparam int AW = aw_of(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic                     wr_conflict
);
`ifdef VLIW_RF_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [NUM_WR-1:0] wv;
  logic conflict_d, conflict_q;
  // Only writes that actually land in the array take part in merging and collision detection.
  always_comb begin
    wv = '0;
    for (int k = 0; k < NUM_WR; k++)
      wv[k] = wr_en[k] && 32'(wr_addr[lo(k, AW) +: AW]) < NUM_REGS
              && !(ZERO_EN && wr_addr[lo(k, AW) +: AW] == AW'(ZERO_ADDR));
  end
  always_comb begin
    conflict_d = 1'b0;
    for (int k = 0; k < NUM_WR; k++)
      for (int m = k + 1; m < NUM_WR; m++)
        if (wv[k] && wv[m] && wr_addr[lo(k, AW) +: AW] == wr_addr[lo(m, AW) +: AW]) conflict_d = 1'b1;
  end
  always_ff @(posedge clk) conflict_q <= !reset && conflict_d;
  assign wr_conflict = conflict_q;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_e
    if (ZERO_EN && i == ZERO_ADDR) begin : g_z
      assign regs[i] = '0;
    end else begin : g_r
      logic [DATA_W-1:0] ent_d, ent_q;
      always_comb begin
        ent_d = ent_q;
        for (int k = 0; k < NUM_WR; k++)
          if (wv[k] && wr_addr[lo(k, AW) +: AW] == AW'(i)) ent_d = wr_data[lo(k, DATA_W) +: DATA_W];
      end
      always_ff @(posedge clk) ent_q <= reset ? '0 : ent_d;
      assign regs[i] = ent_q;
    end
  end
  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = rd_addr[lo(j, AW) +: AW];
    rf_read_port #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_WR(NUM_WR), .AW(AW), .ZERO_EN(ZERO_EN)
    ) u_rp (
      .clk(clk),
      .reset(reset),
      .rd_en(rd_en[j]),
      .rd_addr(ra),
      .arr_word(32'(ra) < NUM_REGS ? regs[ra] : '0),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_data(rd_data[lo(j, DATA_W) +: DATA_W]),
      .rd_valid(rd_valid[j])
    );
  end
endmodule

// File: tb/tb_vliw_regfile_mp.sv
// tb_vliw_regfile_mp: directed table, hand sequences and random traffic against an array-based model.
module tb_vliw_regfile_mp;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] wr_en;
  logic [9:0] wr_addr;
  logic [127:0] wr_data;
  logic [3:0] rd_en;
  logic [19:0] rd_addr;
  logic [255:0] rd_data;
  logic [3:0] rd_valid;
  logic wr_conflict;
  int n_chk = 0, n_fail = 0;
  logic [63:0] mem [32];
  logic [63:0] e_data [4];
  logic [3:0] e_valid;
  logic e_conf;
`ifdef VLIW_RF_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  vliw_regfile_mp dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .wr_conflict(wr_conflict)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] we;
    logic [4:0] wa [2];
    logic [63:0] wd [2];
    logic [3:0] re;
    logic [4:0] ra [4];
    logic [63:0] ed [4];
    logic [3:0] ev;
    logic ec;
  } vec_t;
  vec_t vt [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
  endtask
  task automatic wr(input int k, input logic [4:0] a, input logic [63:0] d);
    wr_en[k] = 1'b1; wr_addr[k*5 +: 5] = a; wr_data[k*64 +: 64] = d;
  endtask
  task automatic rd(input int j, input logic [4:0] a);
    rd_en[j] = 1'b1; rd_addr[j*5 +: 5] = a;
  endtask

  // Reference: writes applied in port order (last wins), reads see the post-write array.
  task automatic model();
    logic [4:0] a0, a1;
    if (reset) begin
      foreach (mem[i]) mem[i] = '0;
      foreach (e_data[j]) e_data[j] = '0;
      e_valid = '0; e_conf = 1'b0;
      return;
    end
    a0 = wr_addr[4:0]; a1 = wr_addr[9:5];
    e_conf = wr_en[0] && wr_en[1] && a0 == a1 && !(ZR && a0 == 0);
    for (int k = 0; k < 2; k++)
      if (wr_en[k] && !(ZR && wr_addr[k*5 +: 5] == 0)) mem[wr_addr[k*5 +: 5]] = wr_data[k*64 +: 64];
    for (int j = 0; j < 4; j++) begin
      e_valid[j] = rd_en[j];
      if (rd_en[j]) e_data[j] = mem[rd_addr[j*5 +: 5]];
    end
  endtask

  task automatic cyc(input string tag);
    model();
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("%s rd_data[%0d]", tag, j), rd_data[j*64 +: 64], e_data[j]);
      chk($sformatf("%s rd_valid[%0d]", tag, j), 64'(rd_valid[j]), 64'(e_valid[j]));
    end
    chk($sformatf("%s wr_conflict", tag), 64'(wr_conflict), 64'(e_conf));
  endtask

  initial begin
    logic [63:0] z0, zc;
    z0 = ZR ? 64'h0 : 64'hFFFF;
    zc = ZR ? 64'h0 : 64'h1;
    vt[0] = '{2'b11, '{5'd3, 5'd4}, '{64'h11, 64'h22}, 4'b0000, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 4'b0000, 1'b0};
    vt[1] = '{2'b00, '{0, 0}, '{0, 0}, 4'b1111, '{5'd3, 5'd4, 5'd3, 5'd4}, '{64'h11, 64'h22, 64'h11, 64'h22}, 4'b1111, 1'b0};
    vt[2] = '{2'b01, '{5'd9, 0}, '{64'hA5A5, 0}, 4'b0100, '{0, 0, 5'd9, 0}, '{64'h11, 64'h22, 64'hA5A5, 64'h22}, 4'b0100, 1'b0};
    vt[3] = '{2'b11, '{5'd6, 5'd6}, '{64'h1, 64'h2}, 4'b0001, '{5'd6, 0, 0, 0}, '{64'h2, 64'h22, 64'hA5A5, 64'h22}, 4'b0001, 1'b1};
    vt[4] = '{2'b00, '{0, 0}, '{0, 0}, 4'b0010, '{0, 5'd6, 0, 0}, '{64'h2, 64'h2, 64'hA5A5, 64'h22}, 4'b0010, 1'b0};
    vt[5] = '{2'b11, '{5'd0, 5'd0}, '{64'hFFFF, 64'hFFFF}, 4'b0001, '{5'd0, 0, 0, 0}, '{z0, 64'h2, 64'hA5A5, 64'h22}, 4'b0001, zc[0]};
    vt[6] = '{2'b00, '{0, 0}, '{0, 0}, 4'b1000, '{0, 0, 0, 5'd0}, '{z0, 64'h2, 64'hA5A5, z0}, 4'b1000, 1'b0};
    vt[7] = '{2'b11, '{5'd2, 5'd2}, '{64'hAA, 64'hBB}, 4'b1111, '{5'd2, 5'd2, 5'd2, 5'd2}, '{64'hBB, 64'hBB, 64'hBB, 64'hBB}, 4'b1111, 1'b1};
    vt[8] = '{2'b11, '{5'd2, 5'd3}, '{64'hCC, 64'hDD}, 4'b0011, '{5'd2, 5'd3, 0, 0}, '{64'hCC, 64'hDD, 64'hBB, 64'hBB}, 4'b0011, 1'b0};

    idle(); reset = 1'b1;
    @(negedge clk);
    cyc("init");
    reset = 1'b0;
    // reset discards a same-cycle write and clears earlier contents
    wr(0, 5'd5, 64'hDEAD_BEEF); cyc("pre_rst");
    idle(); reset = 1'b1; wr(0, 5'd7, 64'h1234); rd(0, 5'd5);
    cyc("rst");
    chk("rst valid", 64'(rd_valid), 64'h0);
    chk("rst conflict", 64'(wr_conflict), 64'h0);
    idle(); reset = 1'b0; rd(0, 5'd5); rd(1, 5'd7);
    cyc("post_rst");
    chk("r5 after reset", rd_data[63:0], 64'h0);
    chk("r7 after reset", rd_data[127:64], 64'h0);

    for (int v = 0; v < 9; v++) begin
      idle();
      wr_en = vt[v].we; rd_en = vt[v].re;
      for (int k = 0; k < 2; k++) begin wr_addr[k*5 +: 5] = vt[v].wa[k]; wr_data[k*64 +: 64] = vt[v].wd[k]; end
      for (int j = 0; j < 4; j++) rd_addr[j*5 +: 5] = vt[v].ra[j];
      model();
      @(posedge clk); #1;
      for (int j = 0; j < 4; j++) chk($sformatf("vec%0d rd_data[%0d]", v, j), rd_data[j*64 +: 64], vt[v].ed[j]);
      chk($sformatf("vec%0d rd_valid", v), 64'(rd_valid), 64'(vt[v].ev));
      chk($sformatf("vec%0d wr_conflict", v), 64'(wr_conflict), 64'(vt[v].ec));
    end

    idle(); rd(0, 5'd6); cyc("r6 later");
    chk("r6 later value", rd_data[63:0], 64'h2);

    for (int n = 1; n <= 8; n++) begin
      idle(); wr(0, 5'd1, 64'(n)); rd(0, 5'd1);
      cyc($sformatf("b2b%0d", n));
      chk($sformatf("b2b%0d r1", n), rd_data[63:0], 64'(n));
    end

    for (int c = 0; c < 400; c++) begin
      int hi;
      idle();
      hi = ($urandom_range(0, 1) == 0) ? 3 : 31;
      reset = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 2) != 0) wr(k, 5'($urandom_range(0, hi)), {$urandom, $urandom});
      for (int j = 0; j < 4; j++)
        if ($urandom_range(0, 2) != 0) rd(j, 5'($urandom_range(0, hi)));
      cyc($sformatf("rnd%0d", c));
    end
    reset = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
